id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register for the 32-bit RISC-V core, sitting directly downstream of the register file. It captures the decoded instruction together with the two register-file read operands. Operands are corrected for same-cycle writeback, because the register file writes on the clock edge and reads combinationally. The block detects load-use hazards and inserts bubbles, and provides a valid/ready handshake with stall, flush and a bubble counter.

## Interface
- XLEN, 32, operand/PC width
- CNT_W, 16, width of bubble counter
- clk  input  1  clock, rising edge
- rst_n_i  input  1  asynchronous active-low reset
- in_valid_i  input  1  decoded instruction valid
- in_ready_o  output  1  stage accepts instruction this cycle
- pc_i, imm_i  input  XLEN  instruction PC, sign-extended immediate
- rs1_i, rs2_i, rd_i  input  5  source/dest register indices (rs1_i/rs2_i also drive register-file read ports)
- use_rs1_i, use_rs2_i  input  1  instruction actually reads rs1/rs2
- alu_op_i  input  4  ALU operation code
- mem_rd_i, mem_wr_i, wb_en_i  input  1  load, store, writes rd
- reg_src_1_dat_i, reg_src_2_dat_i  input  XLEN  register-file read data
- wb_we_i  input  1  writeback strobe (same signal as register-file write enable)
- wb_rd_i  input  5  writeback destination
- wb_dat_i  input  XLEN  writeback data
- flush_i  input  1  kill held/incoming instruction (branch redirect)
- out_ready_i  input  1  execute stage accepts
- out_valid_o  output  1  held instruction valid
- out_pc_o, out_imm_o, out_rs1_dat_o, out_rs2_dat_o  output  XLEN  captured fields/operands
- out_rs1_o, out_rs2_o, out_rd_o  output  5  indices, for downstream forwarding
- out_alu_op_o  output  4
- out_mem_rd_o, out_mem_wr_o, out_wb_en_o  output  1
- bubble_cnt_o  output  CNT_W  saturating count of load-use bubbles

## Operation
- Operand select per source s (s = rs1/rs2), applied in priority order:
  - If s == 0, the operand is 0. x0 is hardwired here because the register file does not hardwire it.
  - Else, if wb_we_i && wb_rd_i == s, the operand is wb_dat_i.
  - Else, the operand is the register-file data.
- Hazard = out_valid_o && out_mem_rd_o && out_rd_o != 0 && ((use_rs1_i && rs1_i == out_rd_o) || (use_rs2_i && rs2_i == out_rd_o)).
- in_ready_o = flush_i || ((!out_valid_o || out_ready_i) && !hazard).
- The block has three register states: EMPTY (out_valid_o=0), FULL (out_valid_o=1) and HOLD (FULL && !out_ready_i).
- Next state, in priority order:
  - flush_i: out_valid_o<=0. The incoming instruction is accepted and dropped.
  - Transfer (in_valid_i && in_ready_o): all out_* fields are loaded and out_valid_o<=1.
  - Hazard && out_ready_i: out_valid_o<=0, forming a bubble. The input is not accepted, and bubble_cnt_o increments, saturating at all-ones.
  - out_ready_i with no new input: out_valid_o<=0.
  - Otherwise: hold.
- HOLD refresh: while held, if wb_we_i && wb_rd_i != 0 && wb_rd_i == out_rs1_o (respectively out_rs2_o), out_rs1_dat_o (respectively out_rs2_dat_o) <= wb_dat_i. This keeps held operands current.
- A bubble carries no side effects. When out_valid_o=0, downstream ignores every other out_* field.

## Timing
- Latency is one cycle from input transfer to out_valid_o.
- Throughput is one instruction per cycle when no hazard occurs and out_ready_i=1.
- in_ready_o is combinational from out_valid_o, out_ready_i, flush_i and the input indices. It has no dependency on in_valid_i.
- A load-use pair costs exactly one bubble cycle. In the following cycle the load has left, the hazard clears and the dependent instruction transfers. Load data is then supplied by downstream forwarding.
- Asynchronous reset drives all outputs to 0: out_valid_o=0, every field 0, bubble_cnt_o=0. Because in_ready_o is combinational, it is 1 during reset when out_valid_o=0.
- Reset asserted mid-HOLD discards the held instruction. No partial state survives.
- Simultaneous events:
  - flush_i wins over hazard, transfer and refresh.
  - A refresh and a same-edge transfer do not conflict, because a transfer replaces the fields.
  - wb bypass with rd=0 is ignored.

## Test plan
- Back-to-back transfer: pipeline of add x3,x1,x2, with reg_src data 5 and 7 and out_ready_i=1 -> out_valid_o=1 one cycle later, out_rs1_dat_o=5, out_rs2_dat_o=7, and in_ready_o stays 1.
- Same-cycle bypass: rs1_i=4, register file returns 0x11, wb_we_i=1, wb_rd_i=4, wb_dat_i=0xAB -> out_rs1_dat_o=0xAB. Repeat with rs1_i=0 and wb_rd_i=0 -> out_rs1_dat_o=0.
- Load-use: held lw x5 (out_mem_rd_o=1), incoming add with rs2=x5 -> in_ready_o=0, one bubble, bubble_cnt_o 0->1, and the add appears on the following cycle.
- HOLD refresh: held instruction with out_rs2_o=9 and out_ready_i=0, then wb x9=0x1234 -> out_rs2_dat_o=0x1234 while out_valid_o stays 1.
- Flush priority: FULL with a hazard pending, then flush_i=1 -> in_ready_o=1, out_valid_o=0 next cycle, incoming instruction dropped, counter unchanged.
- Reset mid-HOLD: assert rst_n_i=0 asynchronously -> all outputs 0 immediately. Saturation: with CNT_W=2, four bubbles -> bubble_cnt_o=3.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: decoded instruction, register-file read data,
// writeback bypass, and the execute-side outputs of the ID/EX register.
interface id_ex_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [XLEN-1:0]  pc_i;
    logic [XLEN-1:0]  imm_i;
    logic [4:0]       rs1_i;
    logic [4:0]       rs2_i;
    logic [4:0]       rd_i;
    logic             use_rs1_i;
    logic             use_rs2_i;
    logic [3:0]       alu_op_i;
    logic             mem_rd_i;
    logic             mem_wr_i;
    logic             wb_en_i;
    logic [XLEN-1:0]  reg_src_1_dat_i;
    logic [XLEN-1:0]  reg_src_2_dat_i;
    logic             wb_we_i;
    logic [4:0]       wb_rd_i;
    logic [XLEN-1:0]  wb_dat_i;
    logic             flush_i;
    logic             out_ready_i;
    logic             out_valid_o;
    logic [XLEN-1:0]  out_pc_o;
    logic [XLEN-1:0]  out_imm_o;
    logic [XLEN-1:0]  out_rs1_dat_o;
    logic [XLEN-1:0]  out_rs2_dat_o;
    logic [4:0]       out_rs1_o;
    logic [4:0]       out_rs2_o;
    logic [4:0]       out_rd_o;
    logic [3:0]       out_alu_op_o;
    logic             out_mem_rd_o;
    logic             out_mem_wr_o;
    logic             out_wb_en_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    modport slave (
        input  in_valid_i, pc_i, imm_i, rs1_i, rs2_i, rd_i, use_rs1_i, use_rs2_i,
               alu_op_i, mem_rd_i, mem_wr_i, wb_en_i, reg_src_1_dat_i, reg_src_2_dat_i,
               wb_we_i, wb_rd_i, wb_dat_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, out_pc_o, out_imm_o, out_rs1_dat_o, out_rs2_dat_o,
               out_rs1_o, out_rs2_o, out_rd_o, out_alu_op_o, out_mem_rd_o, out_mem_wr_o,
               out_wb_en_o, bubble_cnt_o
    );

    modport master (
        output in_valid_i, pc_i, imm_i, rs1_i, rs2_i, rd_i, use_rs1_i, use_rs2_i,
               alu_op_i, mem_rd_i, mem_wr_i, wb_en_i, reg_src_1_dat_i, reg_src_2_dat_i,
               wb_we_i, wb_rd_i, wb_dat_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_pc_o, out_imm_o, out_rs1_dat_o, out_rs2_dat_o,
               out_rs1_o, out_rs2_o, out_rd_o, out_alu_op_o, out_mem_rd_o, out_mem_wr_o,
               out_wb_en_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with same-cycle writeback bypass, load-use bubble
// insertion, flush, held-operand refresh and a saturating bubble counter.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n_i,
    id_ex_stage_if.slave bus
);
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  pc_q, pc_d, imm_q, imm_d;
    logic [XLEN-1:0]  rs1_dat_q, rs1_dat_d, rs2_dat_q, rs2_dat_d;
    logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic             mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d, wb_en_q, wb_en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0]  op1, op2;
    logic             hazard;
    logic             in_ready;

    // x0 is forced here because the register file does not hardwire it.
    always_comb begin
        op1 = bus.reg_src_1_dat_i;
        op2 = bus.reg_src_2_dat_i;
        if (bus.rs1_i == 5'd0) begin
            op1 = '0;
        end else if (bus.wb_we_i && bus.wb_rd_i == bus.rs1_i) begin
            op1 = bus.wb_dat_i;
        end
        if (bus.rs2_i == 5'd0) begin
            op2 = '0;
        end else if (bus.wb_we_i && bus.wb_rd_i == bus.rs2_i) begin
            op2 = bus.wb_dat_i;
        end
    end

    assign hazard = valid_q && mem_rd_q && (rd_q != 5'd0) &&
                    ((bus.use_rs1_i && bus.rs1_i == rd_q) ||
                     (bus.use_rs2_i && bus.rs2_i == rd_q));

    assign in_ready = bus.flush_i || ((!valid_q || bus.out_ready_i) && !hazard);

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        rs1_dat_d = rs1_dat_q;
        rs2_dat_d = rs2_dat_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        alu_op_d  = alu_op_q;
        mem_rd_d  = mem_rd_q;
        mem_wr_d  = mem_wr_q;
        wb_en_d   = wb_en_q;
        cnt_d     = cnt_q;
        if (bus.flush_i) begin
            valid_d = 1'b0;
        end else if (bus.in_valid_i && in_ready) begin
            valid_d   = 1'b1;
            pc_d      = bus.pc_i;
            imm_d     = bus.imm_i;
            rs1_dat_d = op1;
            rs2_dat_d = op2;
            rs1_d     = bus.rs1_i;
            rs2_d     = bus.rs2_i;
            rd_d      = bus.rd_i;
            alu_op_d  = bus.alu_op_i;
            mem_rd_d  = bus.mem_rd_i;
            mem_wr_d  = bus.mem_wr_i;
            wb_en_d   = bus.wb_en_i;
        end else if (hazard && bus.out_ready_i) begin
            valid_d = 1'b0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (bus.out_ready_i) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // Held operands track later writebacks so they are current when released.
            if (bus.wb_we_i && bus.wb_rd_i != 5'd0 && bus.wb_rd_i == rs1_q) begin
                rs1_dat_d = bus.wb_dat_i;
            end
            if (bus.wb_we_i && bus.wb_rd_i != 5'd0 && bus.wb_rd_i == rs2_q) begin
                rs2_dat_d = bus.wb_dat_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            imm_q     <= '0;
            rs1_dat_q <= '0;
            rs2_dat_q <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            alu_op_q  <= '0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            wb_en_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            rs1_dat_q <= rs1_dat_d;
            rs2_dat_q <= rs2_dat_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            alu_op_q  <= alu_op_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            wb_en_q   <= wb_en_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.in_ready_o    = in_ready;
    assign bus.out_valid_o   = valid_q;
    assign bus.out_pc_o      = pc_q;
    assign bus.out_imm_o     = imm_q;
    assign bus.out_rs1_dat_o = rs1_dat_q;
    assign bus.out_rs2_dat_o = rs2_dat_q;
    assign bus.out_rs1_o     = rs1_q;
    assign bus.out_rs2_o     = rs2_q;
    assign bus.out_rd_o      = rd_q;
    assign bus.out_alu_op_o  = alu_op_q;
    assign bus.out_mem_rd_o  = mem_rd_q;
    assign bus.out_mem_wr_o  = mem_wr_q;
    assign bus.out_wb_en_o   = wb_en_q;
    assign bus.bubble_cnt_o  = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven bench for id_ex_stage; a second instance with a 2-bit counter
// shares the stimulus to exercise counter saturation.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst_n_i = 1'b0;
    int   n_tests = 0;
    int   n_failed = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(32), .CNT_W(16)) bus ();
    id_ex_stage_if #(.XLEN(32), .CNT_W(2))  bus2 ();

    id_ex_stage #(.XLEN(32), .CNT_W(16)) dut  (.clk(clk), .rst_n_i(rst_n_i), .bus(bus));
    id_ex_stage #(.XLEN(32), .CNT_W(2))  dut2 (.clk(clk), .rst_n_i(rst_n_i), .bus(bus2));

    assign bus2.in_valid_i      = bus.in_valid_i;
    assign bus2.pc_i            = bus.pc_i;
    assign bus2.imm_i           = bus.imm_i;
    assign bus2.rs1_i           = bus.rs1_i;
    assign bus2.rs2_i           = bus.rs2_i;
    assign bus2.rd_i            = bus.rd_i;
    assign bus2.use_rs1_i       = bus.use_rs1_i;
    assign bus2.use_rs2_i       = bus.use_rs2_i;
    assign bus2.alu_op_i        = bus.alu_op_i;
    assign bus2.mem_rd_i        = bus.mem_rd_i;
    assign bus2.mem_wr_i        = bus.mem_wr_i;
    assign bus2.wb_en_i         = bus.wb_en_i;
    assign bus2.reg_src_1_dat_i = bus.reg_src_1_dat_i;
    assign bus2.reg_src_2_dat_i = bus.reg_src_2_dat_i;
    assign bus2.wb_we_i         = bus.wb_we_i;
    assign bus2.wb_rd_i         = bus.wb_rd_i;
    assign bus2.wb_dat_i        = bus.wb_dat_i;
    assign bus2.flush_i         = bus.flush_i;
    assign bus2.out_ready_i     = bus.out_ready_i;

    typedef struct {
        logic        in_valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        use1, use2, ld;
        logic [31:0] src1, src2;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic        flush, ordy;
        logic        exp_ready;
        logic [31:0] exp_op1, exp_op2;
        logic        exp_valid;
        int          exp_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] pc, imm, op1, op2;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        logic        ld, st, wb;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic iv, input logic [31:0] pc,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                                input logic u1, input logic u2, input logic ld,
                                input logic [31:0] s1, input logic [31:0] s2,
                                input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                                input logic fl, input logic ordy, input logic erdy,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic ev, input int ec);
        vec_t v;
        v.in_valid = iv;  v.pc = pc;   v.rs1 = r1;   v.rs2 = r2;   v.rd = rd;
        v.use1 = u1;      v.use2 = u2; v.ld = ld;    v.src1 = s1;  v.src2 = s2;
        v.we = we;        v.wrd = wrd; v.wdat = wd;  v.flush = fl; v.ordy = ordy;
        v.exp_ready = erdy; v.exp_op1 = e1; v.exp_op2 = e2;
        v.exp_valid = ev;   v.exp_cnt = ec;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic drive_idle();
        bus.in_valid_i = 1'b0; bus.pc_i = '0; bus.imm_i = '0;
        bus.rs1_i = '0; bus.rs2_i = '0; bus.rd_i = '0;
        bus.use_rs1_i = 1'b0; bus.use_rs2_i = 1'b0; bus.alu_op_i = '0;
        bus.mem_rd_i = 1'b0; bus.mem_wr_i = 1'b0; bus.wb_en_i = 1'b0;
        bus.reg_src_1_dat_i = '0; bus.reg_src_2_dat_i = '0;
        bus.wb_we_i = 1'b0; bus.wb_rd_i = '0; bus.wb_dat_i = '0;
        bus.flush_i = 1'b0; bus.out_ready_i = 1'b1;
    endtask

    task automatic apply_stimulus(input vec_t v, input string tag);
        exp_t e;
        int   small_cnt;
        @(negedge clk);
        bus.in_valid_i = v.in_valid;  bus.pc_i = v.pc;  bus.imm_i = ~v.pc;
        bus.rs1_i = v.rs1;  bus.rs2_i = v.rs2;  bus.rd_i = v.rd;
        bus.use_rs1_i = v.use1;  bus.use_rs2_i = v.use2;  bus.alu_op_i = v.pc[5:2];
        bus.mem_rd_i = v.ld;  bus.mem_wr_i = v.pc[2];  bus.wb_en_i = v.pc[3];
        bus.reg_src_1_dat_i = v.src1;  bus.reg_src_2_dat_i = v.src2;
        bus.wb_we_i = v.we;  bus.wb_rd_i = v.wrd;  bus.wb_dat_i = v.wdat;
        bus.flush_i = v.flush;  bus.out_ready_i = v.ordy;
        #1;
        check_output({tag, ".in_ready"}, 32'(bus.in_ready_o), 32'(v.exp_ready));
        if (v.in_valid && v.exp_ready && !v.flush) begin
            e.pc = v.pc;  e.imm = ~v.pc;  e.op1 = v.exp_op1;  e.op2 = v.exp_op2;
            e.rs1 = v.rs1;  e.rs2 = v.rs2;  e.rd = v.rd;  e.alu = v.pc[5:2];
            e.ld = v.ld;  e.st = v.pc[2];  e.wb = v.pc[3];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        small_cnt = (v.exp_cnt > 3) ? 3 : v.exp_cnt;
        check_output({tag, ".out_valid"}, 32'(bus.out_valid_o), 32'(v.exp_valid));
        check_output({tag, ".bubble_cnt"}, 32'(bus.bubble_cnt_o), 32'(v.exp_cnt));
        check_output({tag, ".bubble_cnt_sat"}, 32'(bus2.bubble_cnt_o), 32'(small_cnt));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_output({tag, ".pc"},      bus.out_pc_o,      e.pc);
            check_output({tag, ".imm"},     bus.out_imm_o,     e.imm);
            check_output({tag, ".rs1_dat"}, bus.out_rs1_dat_o, e.op1);
            check_output({tag, ".rs2_dat"}, bus.out_rs2_dat_o, e.op2);
            check_output({tag, ".idx"}, {17'd0, bus.out_rs1_o, bus.out_rs2_o, bus.out_rd_o},
                         {17'd0, e.rs1, e.rs2, e.rd});
            check_output({tag, ".ctrl"},
                         {25'd0, bus.out_alu_op_o, bus.out_mem_rd_o, bus.out_mem_wr_o, bus.out_wb_en_o},
                         {25'd0, e.alu, e.ld, e.st, e.wb});
        end
    endtask

    initial begin
        vec_t v;
        drive_idle();
        #2;
        check_output("reset.out_valid", 32'(bus.out_valid_o), 32'd0);
        check_output("reset.in_ready", 32'(bus.in_ready_o), 32'd1);
        check_output("reset.bubble_cnt", 32'(bus.bubble_cnt_o), 32'd0);
        check_output("reset.rs1_dat", bus.out_rs1_dat_o, 32'd0);
        @(negedge clk);
        rst_n_i = 1'b1;

        //                iv pc      r1 r2 rd u1 u2 ld src1     src2  we wrd wdat   fl or erdy op1      op2   ev cnt
        tbl.push_back(mk(1, 'h100, 1, 2, 3, 1, 1, 0, 5,       7,    0, 0,  0,     0, 1, 1,   5,       7,    1, 0));
        tbl.push_back(mk(1, 'h104, 3, 1, 4, 1, 1, 0, 9,       5,    0, 0,  0,     0, 1, 1,   9,       5,    1, 0));
        tbl.push_back(mk(1, 'h108, 4, 6, 7, 1, 1, 0, 'h11,    'h22, 1, 4,  'hAB,  0, 1, 1,   'hAB,    'h22, 1, 0));
        tbl.push_back(mk(1, 'h10C, 0, 0, 8, 1, 1, 0, 'h55,    'h66, 1, 0,  'hCD,  0, 1, 1,   0,       0,    1, 0));
        tbl.push_back(mk(1, 'h110, 2, 0, 5, 1, 0, 1, 'h1000,  0,    0, 0,  0,     0, 1, 1,   'h1000,  0,    1, 0));
        tbl.push_back(mk(1, 'h114, 1, 5, 6, 1, 1, 0, 5,       'h77, 0, 0,  0,     0, 1, 0,   0,       0,    0, 1));
        tbl.push_back(mk(1, 'h114, 1, 5, 6, 1, 1, 0, 5,       'h77, 0, 0,  0,     0, 1, 1,   5,       'h77, 1, 1));
        tbl.push_back(mk(1, 'h118, 1, 0, 9, 1, 0, 1, 'h20,    0,    0, 0,  0,     0, 1, 1,   'h20,    0,    1, 1));
        tbl.push_back(mk(1, 'h11C, 9, 1, 10, 1, 1, 0, 1,      2,    0, 0,  0,     1, 1, 1,   0,       0,    0, 1));
        tbl.push_back(mk(0, 'h0,   0, 0, 0, 0, 0, 0, 0,       0,    0, 0,  0,     0, 1, 1,   0,       0,    0, 1));
        tbl.push_back(mk(1, 'h120, 1, 0, 5, 1, 0, 1, 3,       0,    0, 0,  0,     0, 1, 1,   3,       0,    1, 1));
        tbl.push_back(mk(1, 'h124, 5, 0, 6, 1, 0, 0, 'h44,    'h99, 0, 0,  0,     0, 0, 0,   0,       0,    1, 1));
        tbl.push_back(mk(1, 'h124, 5, 0, 6, 1, 0, 0, 'h44,    'h99, 0, 0,  0,     0, 1, 0,   0,       0,    0, 2));
        tbl.push_back(mk(1, 'h124, 5, 0, 6, 1, 0, 0, 'h44,    'h99, 0, 0,  0,     0, 1, 1,   'h44,    0,    1, 2));
        tbl.push_back(mk(0, 'h0,   0, 0, 0, 0, 0, 0, 0,       0,    0, 0,  0,     0, 1, 1,   0,       0,    0, 2));
        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus(tbl[i], $sformatf("v%0d", i));
        end

        // Held instruction picks up a later writeback to its rs2.
        apply_stimulus(mk(1, 'h200, 1, 9, 11, 1, 1, 0, 1, 2, 0, 0, 0, 0, 1, 1, 1, 2, 1, 2), "hold.load");
        apply_stimulus(mk(0, 'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 'h1234, 0, 0, 0, 0, 0, 1, 2), "hold.refresh");
        check_output("hold.rs2_dat", bus.out_rs2_dat_o, 32'h1234);
        check_output("hold.rs1_dat", bus.out_rs1_dat_o, 32'd1);
        check_output("hold.pc", bus.out_pc_o, 32'h200);

        // Asynchronous reset in the middle of HOLD.
        bus.wb_we_i = 1'b0;
        #2;
        rst_n_i = 1'b0;
        #1;
        check_output("rst_hold.out_valid", 32'(bus.out_valid_o), 32'd0);
        check_output("rst_hold.pc", bus.out_pc_o, 32'd0);
        check_output("rst_hold.rs2_dat", bus.out_rs2_dat_o, 32'd0);
        check_output("rst_hold.bubble_cnt", 32'(bus.bubble_cnt_o), 32'd0);
        check_output("rst_hold.in_ready", 32'(bus.in_ready_o), 32'd1);
        @(negedge clk);
        rst_n_i = 1'b1;

        // Four load-use pairs: the 2-bit counter must stop at 3.
        for (int k = 1; k <= 4; k++) begin
            v = mk(1, 32'h300 + 32'(k * 16), 0, 0, 5, 0, 0, 1, 'h1, 'h2, 0, 0, 0, 0, 1, 1, 0, 0, 1, k - 1);
            apply_stimulus(v, $sformatf("sat%0d.lw", k));
            v = mk(1, 32'h308 + 32'(k * 16), 5, 0, 6, 1, 0, 0, 'h1, 'h2, 0, 0, 0, 0, 1, 0, 0, 0, 0, k);
            apply_stimulus(v, $sformatf("sat%0d.use", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule
